// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_t;

  // Each radix-4 step retires two multiplier bits; the +1 covers the two extension bits.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_sel_t booth_decode(input logic [2:0] window);
    case (window)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: one 3-bit window picks 0, +-A or +-2A.
module booth_r4_sel
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] pp
);

  localparam int EXT = WIDTH + 2;

  // One guard bit is enough for +-2A of a WIDTH+2 bit signed multiplicand.
  logic [EXT:0] a1;
  assign a1 = {mcand[EXT-1], mcand};

  always_comb begin
    pp = '0;
    unique case (booth_decode(window))
      POS1:    pp = a1;
      POS2:    pp = a1 << 1;
      NEG1:    pp = -a1;
      NEG2:    pp = -(a1 << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
module booth_seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N_ITER = iter_count(WIDTH);
  localparam int EXT    = WIDTH + 2;
  localparam int ACC_W  = 2 * EXT + 1;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  state_t           state;
  logic [EXT-1:0]   mcand;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [EXT:0]     pp;
  logic [EXT:0]     sum;
  logic [ACC_W-1:0] acc_next;

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .window (acc[2:0]),
    .mcand  (mcand),
    .pp     (pp)
  );

  // acc = {high half, multiplier being consumed, implicit Booth bit}; the add is one bit
  // wider than the high half and the arithmetic shift folds that bit back in.
  assign sum      = {acc[ACC_W-1], acc[ACC_W-1 -: EXT]} + pp;
  assign acc_next = {sum[EXT], sum, acc[EXT:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            acc      <= {{EXT{1'b0}}, (tc ? {{2{b[WIDTH-1]}}, b} : {2'b00, b}), 1'b0};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N_ITER - 1)) begin
            p         <= acc_next[2*WIDTH:1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed table, handshake corners, random vs model.
module tb_booth_seq_mul;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, tc, out_valid, out_ready;
  logic [31:0] a, b;
  logic [63:0] p;

  logic        in_valid8, in_ready8, tc8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tc(tc), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .tc(tc8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        tc;
    logic [63:0] exp;
  } vec_t;

  // Reference products straight from integer arithmetic.
  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic m);
    longint sx, sy;
    if (m) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic m);
    int sx, sy;
    if (m) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 16'(sx * sy);
    end
    return 16'({24'b0, x} * {24'b0, y});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  task automatic waitOutValid(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic m,
                               output logic [63:0] res, output int lat);
    @(negedge clk);
    a = x; b = y; tc = m; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid(lat);
    res = p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y, input logic m,
                                output logic [15:0] res, output int lat);
    @(negedge clk);
    a8 = x; b8 = y; tc8 = m; in_valid8 = 1'b1; out_ready8 = 1'b0;
    for (int k = 0; k < 50 && !in_ready8; k++) @(negedge clk);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (out_valid8) begin
        lat = k;
        break;
      end
    end
    res = p8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [63:0] res, exp;
    logic [15:0] res8;
    logic [31:0] x, y;
    logic [7:0]  x8, y8;
    logic        m, seen;
    int          lat;

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; tc = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; tc8 = 0;

    vecs[0] = '{32'd8,         32'd125,        1'b1, 64'd1000};
    vecs[1] = '{32'd225,       32'd30,         1'b0, 64'd6750};
    vecs[2] = '{32'd225,       32'd30,         1'b1, 64'd6750};
    vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0000,  1'b1, 64'h0000_0000_8000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[6] = '{32'd0,         32'hFFFF_FFFF,  1'b0, 64'd0};

    #23;
    checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_p", p, 64'd0);
    checkOutput("reset_p8", {48'b0, p8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tc, res, lat);
      checkOutput($sformatf("table%0d_p", i), res, vecs[i].exp);
      checkOutput($sformatf("table%0d_latency", i), 64'(lat), 64'd17);
    end

    // Back-to-back: in_valid stays high, second request taken right after the handshake.
    @(negedge clk);
    a = 32'd225; b = 32'd30; tc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'd8; b = 32'd125; tc = 1'b1;
    waitOutValid(lat);
    checkOutput("b2b_first_latency", 64'(lat), 64'd17);
    checkOutput("b2b_first_p", p, 64'd6750);
    @(posedge clk); #1;
    checkOutput("b2b_handshake_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("b2b_handshake_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    checkOutput("b2b_second_accepted", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b0;
    waitOutValid(lat);
    checkOutput("b2b_second_latency", 64'(lat), 64'd17);
    checkOutput("b2b_second_p", p, 64'd1000);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Backpressure with operands churning while the result is held.
    exp = model32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; tc = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid(lat);
    checkOutput("bp_latency", 64'(lat), 64'd17);
    for (int k = 0; k < 10; k++) begin
      a = $urandom; b = $urandom; tc = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_out_valid", k), {63'b0, out_valid}, 64'd1);
      checkOutput($sformatf("bp%0d_p", k), p, exp);
      checkOutput($sformatf("bp%0d_in_ready", k), {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of iteration.
    @(negedge clk);
    a = 32'h7777_1111; b = 32'h0BAD_F00D; tc = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("midreset_p", p, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midreset_no_out_valid", {63'b0, seen}, 64'd0);
    applyStimulus(32'hFFFF_FFF9, 32'd9, 1'b1, res, lat);
    checkOutput("post_reset_p", res, 64'hFFFF_FFFF_FFFF_FFC1);
    checkOutput("post_reset_latency", 64'(lat), 64'd17);

    for (int i = 0; i < 100; i++) begin
      x = $urandom; y = $urandom; m = 1'($urandom);
      applyStimulus(x, y, m, res, lat);
      checkOutput($sformatf("rand32_%0d a=%h b=%h tc=%0d", i, x, y, m), res, model32(x, y, m));
    end

    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 1500; i++) begin
        x8 = 8'($urandom); y8 = 8'($urandom);
        if (i == 0) begin x8 = 8'h80; y8 = 8'h80; end
        if (i == 1) begin x8 = 8'hFF; y8 = 8'hFF; end
        applyStimulus8(x8, y8, 1'(mode), res8, lat);
        checkOutput($sformatf("rand8_tc%0d_%0d a=%h b=%h", mode, i, x8, y8),
                    {48'b0, res8}, {48'b0, model8(x8, y8, 1'(mode))});
        if (i < 4)
          checkOutput($sformatf("rand8_tc%0d_latency", mode), 64'(lat), 64'd5);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
